// File: rtl/ir_nec_transmitter_if.sv
// Request/status bundle between game/test logic and the NEC transmitter.
// The master issues send requests; the slave (transmitter) reports progress and drives the LED.
interface ir_nec_transmitter_if;
    logic       Start;
    logic [7:0] Address;
    logic [7:0] Command;
    logic       Busy;
    logic       Done;
    logic       Envelope;
    logic       IR_Out;

    modport master (
        output Start, Address, Command,
        input  Busy, Done, Envelope, IR_Out
    );

    modport slave (
        input  Start, Address, Command,
        output Busy, Done, Envelope, IR_Out
    );
endinterface

// File: rtl/ir_nec_transmitter.sv
// NEC IR frame encoder: lead burst, 32 pulse-distance bits LSB first, stop mark, guard gap.
// Drives an unmodulated envelope and a carrier-modulated LED output, both registered.
//
// state      | meaning
// -----------+---------------------------------------------------
// IDLE       | waiting for Start; Busy=0
// LEAD_MARK  | 16-unit leading burst (mark)
// LEAD_SPACE | 8-unit leading space
// BIT_MARK   | 1-unit mark before each data bit
// BIT_SPACE  | 1-unit (bit 0) or 3-unit (bit 1) space
// STOP_MARK  | 1-unit closing mark
// GAP        | GAP_UNITS of silence before Busy drops
module ir_nec_transmitter #(
    parameter int UNIT_CYCLES    = 28125,
    parameter int CARRIER_CYCLES = 1316,
    parameter int CARRIER_HIGH   = 439,
    parameter int GAP_UNITS      = 64
) (
    input  logic                 Clock,
    input  logic                 Reset_N,
    ir_nec_transmitter_if.slave  bus
);

    localparam int CYC_W = $clog2(UNIT_CYCLES + 1);
    localparam int CAR_W = $clog2(CARRIER_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD_MARK,
        S_LEAD_SPACE,
        S_BIT_MARK,
        S_BIT_SPACE,
        S_STOP_MARK,
        S_GAP
    } state_t;

    state_t             state_q, state_d, state_nxt;
    logic [CYC_W-1:0]   cyc_q, cyc_d;
    logic [15:0]        unit_q, unit_d;
    logic [15:0]        unit_target;
    logic [4:0]         bit_q, bit_d;
    logic [31:0]        shift_q, shift_d;
    logic [CAR_W-1:0]   car_q, car_d;
    logic               env_q, env_d;
    logic               ir_q, ir_d;
    logic               done_q, done_d;
    logic               cyc_last, unit_last;

    function automatic logic is_mark(input state_t s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
    endfunction

    always_comb begin
        unit_target = 16'd1;
        case (state_q)
            S_LEAD_MARK:  unit_target = 16'd16;
            S_LEAD_SPACE: unit_target = 16'd8;
            S_BIT_SPACE:  unit_target = shift_q[0] ? 16'd3 : 16'd1;
            S_GAP:        unit_target = 16'(GAP_UNITS);
            default:      unit_target = 16'd1;
        endcase
    end

    assign cyc_last  = (cyc_q == CYC_W'(UNIT_CYCLES - 1));
    assign unit_last = (unit_q == unit_target - 16'd1);

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_LEAD_MARK:  state_nxt = S_LEAD_SPACE;
            S_LEAD_SPACE: state_nxt = S_BIT_MARK;
            S_BIT_MARK:   state_nxt = S_BIT_SPACE;
            S_BIT_SPACE:  state_nxt = (bit_q == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
            S_STOP_MARK:  state_nxt = S_GAP;
            S_GAP:        state_nxt = S_IDLE;
            default:      state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        unit_d  = unit_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        car_d   = '0;
        done_d  = 1'b0;

        if (state_q == S_IDLE) begin
            if (bus.Start) begin
                shift_d = {~bus.Command, bus.Command, ~bus.Address, bus.Address};
                state_d = S_LEAD_MARK;
                cyc_d   = '0;
                unit_d  = '0;
                bit_d   = '0;
            end
        end else if (cyc_last) begin
            cyc_d = '0;
            if (unit_last) begin
                unit_d  = '0;
                state_d = state_nxt;
                if (state_q == S_BIT_SPACE) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 5'd1;
                end
                if (state_q == S_GAP) begin
                    done_d = 1'b1;
                end
            end else begin
                unit_d = unit_q + 16'd1;
            end
        end else begin
            cyc_d = cyc_q + CYC_W'(1);
        end

        // Mark states are never adjacent, so entering one always restarts the carrier high.
        env_d = is_mark(state_d);
        if (env_d && is_mark(state_q)) begin
            car_d = (car_q == CAR_W'(CARRIER_CYCLES - 1)) ? '0 : car_q + CAR_W'(1);
        end
        ir_d = env_d && (car_d < CAR_W'(CARRIER_HIGH));
    end

    always_ff @(posedge Clock or negedge Reset_N) begin
        if (!Reset_N) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            unit_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            car_q   <= '0;
            env_q   <= 1'b0;
            ir_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            unit_q  <= unit_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            car_q   <= car_d;
            env_q   <= env_d;
            ir_q    <= ir_d;
            done_q  <= done_d;
        end
    end

    assign bus.Busy     = (state_q != S_IDLE);
    assign bus.Done     = done_q;
    assign bus.Envelope = env_q;
    assign bus.IR_Out   = ir_q;

endmodule

// File: tb/tb_ir_nec_transmitter.sv
// Directed bench for ir_nec_transmitter with shortened timing (10-cycle unit, 4-cycle carrier).
// Expected waveforms come from a segment-table model; data is also decoded back from the envelope.
module tb_ir_nec_transmitter;

    localparam int UC    = 10;
    localparam int CC    = 4;
    localparam int CH    = 1;
    localparam int GU    = 64;
    localparam int FRAME = 1850;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    logic env_s   [1:FRAME+1];
    logic exp_env [1:FRAME+1];
    logic exp_ir  [1:FRAME+1];
    int   mk;

    ir_nec_transmitter_if bus ();

    ir_nec_transmitter #(
        .UNIT_CYCLES   (UC),
        .CARRIER_CYCLES(CC),
        .CARRIER_HIGH  (CH),
        .GAP_UNITS     (GU)
    ) dut (
        .Clock  (clk),
        .Reset_N(rst_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_seg(input logic mark, input int n);
        for (int i = 0; i < n; i++) begin
            exp_env[mk] = mark;
            exp_ir[mk]  = mark && ((i % CC) < CH);
            mk++;
        end
    endtask

    task automatic build_model(input logic [31:0] w);
        mk = 1;
        add_seg(1'b1, 16 * UC);
        add_seg(1'b0, 8 * UC);
        for (int b = 0; b < 32; b++) begin
            add_seg(1'b1, UC);
            add_seg(1'b0, w[b] ? 3 * UC : UC);
        end
        add_seg(1'b1, UC);
        add_seg(1'b0, GU * UC);
        add_seg(1'b0, 1);
    endtask

    function automatic logic [31:0] decode_env();
        logic [31:0] w;
        int i;
        int len;
        w = '0;
        i = 1;
        while (i <= FRAME && env_s[i] === 1'b1) i++;
        while (i <= FRAME && env_s[i] !== 1'b1) i++;
        for (int b = 0; b < 32; b++) begin
            while (i <= FRAME && env_s[i] === 1'b1) i++;
            len = 0;
            while (i <= FRAME && env_s[i] !== 1'b1) begin
                len++;
                i++;
            end
            w[b] = (len > 2 * UC);
        end
        return w;
    endfunction

    // Call with Start already raised so that the coming rising edge accepts it.
    task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] c,
                             input int poke_k, input int nxt_k,
                             input logic [7:0] na, input logic [7:0] nc);
        logic [31:0] word;
        int env_err, ir_err, busy_err, done_err, busy_cnt, done_cnt;
        word = {~c, c, ~a, a};
        build_model(word);
        env_err = 0; ir_err = 0; busy_err = 0; done_err = 0; busy_cnt = 0; done_cnt = 0;
        for (int k = 1; k <= FRAME + 1; k++) begin
            @(negedge clk);
            if (k == 1) bus.Start = 1'b0;
            if (k == poke_k) begin
                bus.Start   = 1'b1;
                bus.Address = 8'h12;
                bus.Command = 8'h34;
            end
            if (k == poke_k + 1) bus.Start = 1'b0;
            if (k == nxt_k) begin
                bus.Start   = 1'b1;
                bus.Address = na;
                bus.Command = nc;
            end
            env_s[k] = bus.Envelope;
            if (bus.Envelope !== exp_env[k]) env_err++;
            if (bus.IR_Out !== exp_ir[k]) ir_err++;
            if (bus.Busy !== (k <= FRAME)) busy_err++;
            if (bus.Done !== (k == FRAME + 1)) done_err++;
            if (bus.Busy === 1'b1) busy_cnt++;
            if (bus.Done === 1'b1) done_cnt++;
        end
        chk({tag, "_env_err"}, env_err, 0);
        chk({tag, "_ir_err"}, ir_err, 0);
        chk({tag, "_busy_err"}, busy_err, 0);
        chk({tag, "_done_err"}, done_err, 0);
        chk({tag, "_busy_len"}, busy_cnt, FRAME);
        chk({tag, "_done_cnt"}, done_cnt, 1);
        chk({tag, "_decoded"}, decode_env(), word);
    endtask

    task automatic outs_now(input string tag, input logic [3:0] exp);
        chk(tag, {bus.Busy, bus.Done, bus.Envelope, bus.IR_Out}, exp);
    endtask

    task automatic quiet(input string tag, input int n);
        int act;
        act = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if ({bus.Busy, bus.Done, bus.Envelope, bus.IR_Out} !== 4'b0000) act++;
        end
        chk(tag, act, 0);
    endtask

    task automatic mid_reset(input string tag, input int k_at, input logic [3:0] pre);
        int dn;
        @(negedge clk);
        bus.Start   = 1'b1;
        bus.Address = 8'h00;
        bus.Command = 8'h45;
        @(negedge clk);
        bus.Start = 1'b0;
        repeat (k_at - 1) @(negedge clk);
        outs_now({tag, "_pre"}, pre);
        rst_n = 1'b0;
        #1;
        outs_now({tag, "_instant"}, 4'b0000);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.Done !== 1'b0) dn++;
        end
        chk({tag, "_no_done"}, dn, 0);
        rst_n = 1'b1;
        quiet({tag, "_after"}, 3000);
    endtask

    initial begin
        bus.Start   = 1'b0;
        bus.Address = 8'h00;
        bus.Command = 8'h00;
        rst_n       = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        outs_now("reset_outs", 4'b0000);
        rst_n = 1'b1;
        quiet("idle_after_reset", 100);

        @(negedge clk);
        bus.Start   = 1'b1;
        bus.Address = 8'h00;
        bus.Command = 8'h45;
        run_frame("f1", 8'h00, 8'h45, 0, 0, 8'h00, 8'h00);

        @(negedge clk);
        bus.Start   = 1'b1;
        bus.Address = 8'h00;
        bus.Command = 8'h45;
        run_frame("busy_poke", 8'h00, 8'h45, 500, 0, 8'h00, 8'h00);
        quiet("no_second_frame", 300);

        @(negedge clk);
        bus.Start   = 1'b1;
        bus.Address = 8'h00;
        bus.Command = 8'h45;
        run_frame("b2b_a", 8'h00, 8'h45, 0, 1800, 8'hA5, 8'h0F);
        run_frame("b2b_b", 8'hA5, 8'h0F, 0, 0, 8'h00, 8'h00);
        quiet("b2b_end", 50);

        mid_reset("rst_lead_space", 199, 4'b1000);
        mid_reset("rst_bit_mark", 245, 4'b1011);

        @(negedge clk);
        bus.Start   = 1'b1;
        bus.Address = 8'h3C;
        bus.Command = 8'h81;
        run_frame("post_reset", 8'h3C, 8'h81, 0, 0, 8'h00, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
